// File: rtl/fpcvt_pipe.sv
`default_nettype none
// ============================================================================
// Module      : fpcvt_pipe
// Description : Three-stage elastic converter from a two's-complement sample to
//               sign / exponent / significand with optional round-half-up.
// Revision    : 1.0 - initial release
// ============================================================================
module fpcvt_pipe #(
    parameter int DW = 12,
    parameter int EW = 3,
    parameter int FW = 4,
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] D,
    input  logic          rnd_en,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          S,
    output logic [EW-1:0] E,
    output logic [FW-1:0] F,
    output logic          sat,
    output logic [CW-1:0] sat_cnt
);

    localparam int MW = DW - 1;
    localparam int PW = $clog2(DW);
    localparam logic [DW-1:0] MIN_NEG = {1'b1, {MW{1'b0}}};

    generate
        if (DW != FW + 2**EW) begin : g_bad_params
            $error("fpcvt_pipe: DW must equal FW + 2**EW");
        end
    endgenerate

    logic          v1_q, v1_d, s1_q, s1_d, rnd1_q, rnd1_d, ovf1_q, ovf1_d;
    logic [MW-1:0] mag1_q, mag1_d;
    logic          v2_q, v2_d, s2_q, s2_d, rnd2_q, rnd2_d, ovf2_q, ovf2_d;
    logic [MW-1:0] mag2_q, mag2_d;
    logic [PW-1:0] p2_q, p2_d;
    logic          v3_q, v3_d, s3_q, s3_d, sat3_q, sat3_d;
    logic [EW-1:0] e3_q, e3_d;
    logic [FW-1:0] f3_q, f3_d;
    logic [CW-1:0] sat_cnt_q, sat_cnt_d;

    logic          ld1, ld2, ld3;
    logic [PW-1:0] p_enc, sh;
    logic [EW-1:0] e_t;
    logic [FW-1:0] f_t;
    logic          r_t;

    // A stage advances when it is empty or its successor advances.
    assign ld3      = !v3_q || out_ready;
    assign ld2      = !v2_q || ld3;
    assign ld1      = !v1_q || ld2;
    assign in_ready = rst_n && ld1;

    assign out_valid = v3_q;
    assign S         = s3_q;
    assign E         = e3_q;
    assign F         = f3_q;
    assign sat       = sat3_q;
    assign sat_cnt   = sat_cnt_q;

    always_comb begin
        v1_d   = v1_q;
        s1_d   = s1_q;
        rnd1_d = rnd1_q;
        ovf1_d = ovf1_q;
        mag1_d = mag1_q;
        if (ld1) begin
            v1_d   = in_valid;
            s1_d   = D[DW-1];
            rnd1_d = rnd_en;
            ovf1_d = (D == MIN_NEG);
            if (D == MIN_NEG) begin
                mag1_d = '1;
            end else if (D[DW-1]) begin
                mag1_d = ~D[MW-1:0] + 1'b1;
            end else begin
                mag1_d = D[MW-1:0];
            end
        end
    end

    always_comb begin
        p_enc = '0;
        for (int i = 0; i < MW; i++) begin
            if (mag1_q[i]) p_enc = PW'(i);
        end
        v2_d   = v2_q;
        s2_d   = s2_q;
        rnd2_d = rnd2_q;
        ovf2_d = ovf2_q;
        mag2_d = mag2_q;
        p2_d   = p2_q;
        if (ld2) begin
            v2_d   = v1_q;
            s2_d   = s1_q;
            rnd2_d = rnd1_q;
            ovf2_d = ovf1_q;
            mag2_d = mag1_q;
            p2_d   = p_enc;
        end
    end

    always_comb begin
        sh  = p2_q - PW'(FW);
        e_t = '0;
        f_t = mag2_q[FW-1:0];
        r_t = 1'b0;
        if (p2_q >= PW'(FW)) begin
            e_t = EW'(sh) + 1'b1;
            f_t = FW'(mag2_q >> (sh + 1'b1));
            r_t = mag2_q[sh];
        end
        e3_d   = e3_q;
        f3_d   = f3_q;
        s3_d   = s3_q;
        sat3_d = sat3_q;
        v3_d   = v3_q;
        if (ld3) begin
            v3_d   = v2_q;
            s3_d   = s2_q;
            e3_d   = e_t;
            f3_d   = f_t;
            sat3_d = ovf2_q;
            if (rnd2_q && r_t) begin
                if (&f_t) begin
                    // Carry out of the significand renormalises, or clamps at the top exponent.
                    if (&e_t) begin
                        sat3_d = 1'b1;
                    end else begin
                        e3_d = e_t + 1'b1;
                        f3_d = {1'b1, {(FW-1){1'b0}}};
                    end
                end else begin
                    f3_d = f_t + 1'b1;
                end
            end
            if (sat3_d) begin
                e3_d = '1;
                f3_d = '1;
            end
        end
    end

    always_comb begin
        sat_cnt_d = sat_cnt_q;
        if (v3_q && out_ready && sat3_q && !(&sat_cnt_q)) begin
            sat_cnt_d = sat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q      <= 1'b0;
            s1_q      <= 1'b0;
            rnd1_q    <= 1'b0;
            ovf1_q    <= 1'b0;
            mag1_q    <= '0;
            v2_q      <= 1'b0;
            s2_q      <= 1'b0;
            rnd2_q    <= 1'b0;
            ovf2_q    <= 1'b0;
            mag2_q    <= '0;
            p2_q      <= '0;
            v3_q      <= 1'b0;
            s3_q      <= 1'b0;
            e3_q      <= '0;
            f3_q      <= '0;
            sat3_q    <= 1'b0;
            sat_cnt_q <= '0;
        end else begin
            v1_q      <= v1_d;
            s1_q      <= s1_d;
            rnd1_q    <= rnd1_d;
            ovf1_q    <= ovf1_d;
            mag1_q    <= mag1_d;
            v2_q      <= v2_d;
            s2_q      <= s2_d;
            rnd2_q    <= rnd2_d;
            ovf2_q    <= ovf2_d;
            mag2_q    <= mag2_d;
            p2_q      <= p2_d;
            v3_q      <= v3_d;
            s3_q      <= s3_d;
            e3_q      <= e3_d;
            f3_q      <= f3_d;
            sat3_q    <= sat3_d;
            sat_cnt_q <= sat_cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fpcvt_pipe.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpcvt_pipe
// Description : Directed self-checking bench for fpcvt_pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpcvt_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [11:0] D;
    logic        rnd_en;
    logic        out_valid;
    logic        out_ready;
    logic        S;
    logic [2:0]  E;
    logic [3:0]  F;
    logic        sat;
    logic [7:0]  sat_cnt;

    int n_assert = 0;
    int n_fail   = 0;

    fpcvt_pipe #(.DW(12), .EW(3), .FW(4), .CW(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .D         (D),
        .rnd_en    (rnd_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .S         (S),
        .E         (E),
        .F         (F),
        .sat       (sat),
        .sat_cnt   (sat_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One isolated transfer: latency is 3 edges, result consumed on the next edge.
    task automatic xfer(input string tag, input logic [11:0] d, input logic r,
                        input logic es, input logic [2:0] ee, input logic [3:0] ef,
                        input logic esat, input logic [7:0] ecnt);
        @(negedge clk);
        in_valid = 1'b1;
        D        = d;
        rnd_en   = r;
        #1 check({tag, "_in_ready"}, in_ready, 1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_S"}, S, es);
        check({tag, "_E"}, E, ee);
        check({tag, "_F"}, F, ef);
        check({tag, "_sat"}, sat, esat);
        @(negedge clk);
        check({tag, "_sat_cnt"}, sat_cnt, ecnt);
    endtask

    logic [11:0] sd [6] = '{12'd422, 12'd125, 12'd125, 12'hE5A, 12'd16, 12'd7};
    logic        sr [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    logic        ss [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [2:0]  se [6] = '{3'd5, 3'd4, 3'd3, 3'd5, 3'd1, 3'd0};
    logic [3:0]  sf [6] = '{4'd13, 4'd8, 4'd15, 4'd13, 4'd8, 4'd7};

    initial begin
        int sent;
        int got;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        D         = '0;
        rnd_en    = 1'b1;
        out_ready = 1'b1;

        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_S", S, 0);
        check("rst_E", E, 0);
        check("rst_F", F, 0);
        check("rst_sat", sat, 0);
        check("rst_sat_cnt", sat_cnt, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1 check("release_in_ready", in_ready, 1);

        xfer("d0",       12'd0,    1'b1, 1'b0, 3'd0, 4'd0,  1'b0, 8'd0);
        xfer("d422",     12'd422,  1'b1, 1'b0, 3'd5, 4'd13, 1'b0, 8'd0);
        xfer("d125_r1",  12'd125,  1'b1, 1'b0, 3'd4, 4'd8,  1'b0, 8'd0);
        xfer("d125_r0",  12'd125,  1'b0, 1'b0, 3'd3, 4'd15, 1'b0, 8'd0);
        xfer("d7",       12'd7,    1'b1, 1'b0, 3'd0, 4'd7,  1'b0, 8'd0);
        xfer("d15",      12'd15,   1'b1, 1'b0, 3'd0, 4'd15, 1'b0, 8'd0);
        xfer("d16",      12'd16,   1'b1, 1'b0, 3'd1, 4'd8,  1'b0, 8'd0);
        xfer("d31_r1",   12'd31,   1'b1, 1'b0, 3'd2, 4'd8,  1'b0, 8'd0);
        xfer("d31_r0",   12'd31,   1'b0, 1'b0, 3'd1, 4'd15, 1'b0, 8'd0);
        xfer("d1023_r0", 12'd1023, 1'b0, 1'b0, 3'd6, 4'd15, 1'b0, 8'd0);
        xfer("d1023_r1", 12'd1023, 1'b1, 1'b0, 3'd7, 4'd8,  1'b0, 8'd0);
        xfer("dm422",    12'hE5A,  1'b1, 1'b1, 3'd5, 4'd13, 1'b0, 8'd0);
        xfer("dm1",      12'hFFF,  1'b1, 1'b1, 3'd0, 4'd1,  1'b0, 8'd0);
        xfer("dmin_r1",  12'h800,  1'b1, 1'b1, 3'd7, 4'd15, 1'b1, 8'd1);
        xfer("d2047_r1", 12'd2047, 1'b1, 1'b0, 3'd7, 4'd15, 1'b1, 8'd2);
        xfer("dmin_r0",  12'h800,  1'b0, 1'b1, 3'd7, 4'd15, 1'b1, 8'd3);
        xfer("d2047_r0", 12'd2047, 1'b0, 1'b0, 3'd7, 4'd15, 1'b0, 8'd3);

        // Back-pressure: consumer stalls for the first 5 cycles of the stream.
        sent = 0;
        got  = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 5);
            in_valid  = (sent < 6);
            if (sent < 6) begin
                D      = sd[sent];
                rnd_en = sr[sent];
            end
            #1;
            if (cyc == 3) begin
                check("stall_in_ready", in_ready, 0);
                check("stall_accepted", sent, 3);
            end
            if (out_valid) begin
                check($sformatf("stream%0d_S", got), S, ss[got]);
                check($sformatf("stream%0d_E", got), E, se[got]);
                check($sformatf("stream%0d_F", got), F, sf[got]);
                check($sformatf("stream%0d_sat", got), sat, 0);
                if (out_ready) got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        check("stream_complete", got, 6);
        check("stream_sent", sent, 6);

        // Asynchronous reset with results in flight.
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        D         = 12'd2047;
        rnd_en    = 1'b1;
        @(negedge clk);
        D = 12'd16;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("inflight_valid", out_valid, 1);
        #3 rst_n = 1'b0;
        #1;
        check("async_out_valid", out_valid, 0);
        check("async_sat_cnt", sat_cnt, 0);
        check("async_in_ready", in_ready, 0);
        check("async_E", E, 0);
        check("async_F", F, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1 check("rerelease_in_ready", in_ready, 1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("no_stale_%0d", i), out_valid, 0);
        end

        // Saturation counter: exact count, then sticking at all ones.
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            D        = 12'd2047;
            rnd_en   = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("sat_cnt_10", sat_cnt, 10);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("sat_cnt_sticky", sat_cnt, 255);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/fpcvt_pipe.md
FPCVT_PIPE -- requirements
Module: fpcvt_pipe

Interface
REQ-001 Parameter DW, 12, input width of the two's-complement sample D.
REQ-002 Parameter EW, 3, exponent field width.
REQ-003 Parameter FW, 4, significand field width; elaboration SHALL fail unless DW == FW + 2**EW.
REQ-004 Parameter CW, 8, width of the saturation event counter.
REQ-005 Port clk, in, 1, the only clock; all state is rising-edge.
REQ-006 Port rst_n, in, 1, reset, asynchronous and active-low.
REQ-007 Port in_valid, in, 1, D and rnd_en are presented.
REQ-008 Port in_ready, out, 1, the block accepts the input this cycle.
REQ-009 Port D, in, DW, two's-complement linear sample.
REQ-010 Port rnd_en, in, 1, 1 = round-half-up, 0 = truncate; sampled with D.
REQ-011 Port out_valid, out, 1, S/E/F/sat hold a result.
REQ-012 Port out_ready, in, 1, the consumer takes the result this cycle.
REQ-013 Port S, out, 1, sign.
REQ-014 Port E, out, EW, exponent.
REQ-015 Port F, out, FW, significand; value = F * 2**E.
REQ-016 Port sat, out, 1, the result was clamped to the maximum magnitude.
REQ-017 Port sat_cnt, out, CW, count of transferred results with sat=1.

Function
REQ-018 An input transfer SHALL occur when in_valid && in_ready; an output transfer SHALL occur when out_valid && out_ready.
REQ-019 The pipeline SHALL have three register stages (capture/magnitude, leading-one encode, shift/round), each with a valid bit.
REQ-020 Stage k SHALL load when it is empty or stage k+1 loads; the last stage loads when empty or when an output transfer occurs; in_ready SHALL equal the stage-1 load condition.
REQ-021 Latency SHALL be 3 cycles from input transfer to out_valid with out_ready held high; throughput SHALL be one result per cycle.
REQ-022 With out_ready low, a result SHALL hold S/E/F/sat stable; no input SHALL be lost or duplicated; order SHALL be preserved.
REQ-023 Stage 1: S = D[DW-1]; mag = -D when S=1, else D; D = -2**(DW-1) SHALL give mag = 2**(DW-1)-1 and force sat.
REQ-024 Stage 2: p = index of the most significant 1 in mag[DW-2:0]; mag = 0 SHALL give p = 0.
REQ-025 Stage 3, p < FW: E = 0, F = mag[FW-1:0], no rounding.
REQ-026 Stage 3, p >= FW: E = p-FW+1, F = mag[p:p-FW+1], round bit r = mag[p-FW].
REQ-027 If rnd_en && r: F+1 that overflows FW bits SHALL give F = 2**(FW-1) and E+1.
REQ-028 If that overflow occurs at E = 2**EW-1: E and F SHALL be all ones and sat = 1.
REQ-029 rnd_en SHALL travel with its sample; changing rnd_en while stalled SHALL NOT affect samples already accepted.
REQ-030 sat_cnt SHALL increment on each output transfer with sat=1 and SHALL stick at all-ones (no wrap).

Reset
REQ-031 rst_n low SHALL immediately clear all valid bits and sat_cnt, regardless of the clock.
REQ-032 During reset out_valid = 0, in_ready = 0, S = 0, E = 0, F = 0, sat = 0, sat_cnt = 0.
REQ-033 In-flight samples SHALL be discarded on reset; in_ready SHALL rise in the first cycle after rst_n is released.

Verification
REQ-034 Defaults, rnd_en=1, out_ready=1: D=0 -> S0 E0 F0 sat0; D=422 -> S0 E5 F1101 sat0, 3 cycles later.
REQ-035 D=125: rnd_en=1 -> E4 F1000; rnd_en=0 -> E3 F1111.
REQ-036 D=12'h800 -> S1 E7 F1111 sat1, sat_cnt 0->1; D=2047 rnd_en=1 -> S0 E7 F1111 sat1.
REQ-037 Stream 6 samples with out_ready low for 5 cycles, then high -> in_ready falls after 3 accepted; all 6 results emerge in order, unchanged while stalled.
REQ-038 rst_n pulsed low between clock edges with 2 samples in flight -> out_valid falls at once, sat_cnt = 0, no stale output after release.
REQ-039 Over 300 saturating transfers with CW=8 -> sat_cnt holds at 255.
